// File: rtl/addsubcmp_pkg.sv
// Shared mode codes, FSM state encoding and initial-carry helper for the
// sequential multi-word add/subtract/compare engine.
package addsubcmp_pkg;

  localparam logic [1:0] MODE_ADD  = 2'b00;
  localparam logic [1:0] MODE_SUB  = 2'b01;
  localparam logic [1:0] MODE_CMP  = 2'b10;
  localparam logic [1:0] MODE_ADDC = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Subtraction is A + ~B + 1, so sub/cmp seed the chain with a carry of 1.
  function automatic logic init_carry(input logic [1:0] mode, input logic carry_in);
    logic c;
    case (mode)
      MODE_SUB, MODE_CMP: c = 1'b1;
      MODE_ADDC:          c = carry_in;
      default:            c = 1'b0;
    endcase
    return c;
  endfunction

  function automatic logic invert_b(input logic [1:0] mode);
    return (mode == MODE_SUB) || (mode == MODE_CMP);
  endfunction

endpackage

// File: rtl/addsubcmp_slice.sv
// One WordWidth-bit adder slice with optional B inversion; also exposes the
// carry into the MSB so the sequencer can form two's-complement overflow.
module addsubcmp_slice #(
  parameter int WordWidth = 16
) (
  input  logic [WordWidth-1:0] a_i,
  input  logic [WordWidth-1:0] b_i,
  input  logic                 inv_b_i,
  input  logic                 carry_i,
  output logic [WordWidth-1:0] sum_o,
  output logic                 carry_o,
  output logic                 msb_carry_o
);

  logic [WordWidth-1:0] b_x;
  logic [WordWidth-1:0] low;
  logic                 a_msb;
  logic                 b_msb;

  assign b_x   = inv_b_i ? ~b_i : b_i;
  assign a_msb = a_i[WordWidth-1];
  assign b_msb = b_x[WordWidth-1];

  // Add the low bits one position wider so the top bit is the carry into the MSB.
  assign low = {1'b0, a_i[WordWidth-2:0]} + {1'b0, b_x[WordWidth-2:0]}
             + {{(WordWidth-1){1'b0}}, carry_i};

  assign msb_carry_o = low[WordWidth-1];
  assign sum_o       = {a_msb ^ b_msb ^ msb_carry_o, low[WordWidth-2:0]};
  assign carry_o     = (a_msb & b_msb) | (msb_carry_o & (a_msb ^ b_msb));

endmodule

// File: rtl/addsubcmp_seq.sv
// Multi-word add/sub/cmp engine: one slice per cycle, LSW first, valid/ready on
// both sides. Define ADDSUBCMP_SEQ_SATURATE_EN to clamp overflowing results.
module addsubcmp_seq
  import addsubcmp_pkg::*;
#(
  parameter int WordWidth = 16,
  parameter int NumWords  = 4
) (
  input  logic                          Clk_i,
  input  logic                          Reset_i,
  input  logic                          Valid_i,
  output logic                          Ready_o,
  input  logic [1:0]                    Mode_i,
  input  logic                          Carry_i,
  input  logic [WordWidth*NumWords-1:0] A_i,
  input  logic [WordWidth*NumWords-1:0] B_i,
  output logic                          Valid_o,
  input  logic                          Ready_i,
  output logic [WordWidth*NumWords-1:0] D_o,
  output logic                          Carry_o,
  output logic                          Zero_o,
  output logic                          Sign_o,
  output logic                          Overflow_o
);

  localparam int W    = WordWidth * NumWords;
  localparam int IdxW = (NumWords > 1) ? $clog2(NumWords) : 1;

  state_e            state_q;
  logic [W-1:0]      a_q;
  logic [W-1:0]      b_q;
  logic [W-1:0]      res_q;
  logic [1:0]        mode_q;
  logic              carry_q;
  logic              zacc_q;
  logic [IdxW-1:0]   idx_q;
  logic [W-1:0]      d_q;
  logic              carry_o_q;
  logic              zero_q;
  logic              sign_q;
  logic              ovf_q;

  logic [WordWidth-1:0] a_slice;
  logic [WordWidth-1:0] b_slice;
  logic [WordWidth-1:0] sum;
  logic                 cout;
  logic                 msb_c;
  logic                 last;
  logic                 is_cmp;
  logic                 zero_d;
  logic                 ovf_d;
  logic [W-1:0]         res_full;
  logic [W-1:0]         d_d;

  addsubcmp_slice #(.WordWidth(WordWidth)) u_slice (
    .a_i         (a_slice),
    .b_i         (b_slice),
    .inv_b_i     (invert_b(mode_q)),
    .carry_i     (carry_q),
    .sum_o       (sum),
    .carry_o     (cout),
    .msb_carry_o (msb_c)
  );

  always_comb begin
    a_slice  = a_q[idx_q*WordWidth +: WordWidth];
    b_slice  = b_q[idx_q*WordWidth +: WordWidth];
    last     = (idx_q == IdxW'(NumWords - 1));
    is_cmp   = (mode_q == MODE_CMP);
    zero_d   = zacc_q & (sum == '0);
    ovf_d    = msb_c ^ cout;
    // The top slice is still in flight on the last cycle, so splice it in here.
    res_full = res_q;
    res_full[W-1 -: WordWidth] = sum;
    d_d      = res_full;
`ifdef ADDSUBCMP_SEQ_SATURATE_EN
    if (ovf_d) begin
      d_d = a_q[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
`endif
    if (is_cmp) begin
      d_d = '0;
    end
  end

  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      mode_q    <= MODE_ADD;
      carry_q   <= 1'b0;
      zacc_q    <= 1'b0;
      idx_q     <= '0;
      d_q       <= '0;
      carry_o_q <= 1'b0;
      zero_q    <= 1'b0;
      sign_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Valid_i) begin
            a_q     <= A_i;
            b_q     <= B_i;
            mode_q  <= Mode_i;
            carry_q <= init_carry(Mode_i, Carry_i);
            idx_q   <= '0;
            zacc_q  <= 1'b1;
            res_q   <= '0;
            state_q <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (!is_cmp) begin
            res_q[idx_q*WordWidth +: WordWidth] <= sum;
          end
          carry_q <= cout;
          zacc_q  <= zero_d;
          idx_q   <= idx_q + 1'b1;
          if (last) begin
            d_q       <= d_d;
            carry_o_q <= cout;
            zero_q    <= zero_d;
            sign_q    <= sum[WordWidth-1];
            ovf_q     <= ovf_d;
            state_q   <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (Ready_i) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign Ready_o    = (state_q == ST_IDLE);
  assign Valid_o    = (state_q == ST_DONE);
  assign D_o        = d_q;
  assign Carry_o    = carry_o_q;
  assign Zero_o     = zero_q;
  assign Sign_o     = sign_q;
  assign Overflow_o = ovf_q;

endmodule

// File: doc/addsubcmp_seq.md
Name: addsubcmp_seq

Overview:
Parametrised multi-word add/subtract/compare engine, successor to the fixed 16-bit AddSubCmp add wrapper. Operands of NumWords*WordWidth bits are processed one WordWidth slice per cycle through a single carry-chained slice, LSW first, and full AddSubCmp flags are produced. Sits in the wsn-soc cell library as a reconfigurable-fabric cell for wide (32/48/64-bit) sensor arithmetic, with valid/ready on input and output.

Parameters:
WordWidth, 16, width of one slice processed per cycle (>=2)
NumWords, 4, number of slices; operand width W = WordWidth*NumWords (>=1)

Ports:
Clk_i  in  1  clock, rising edge
Reset_i  in  1  synchronous reset, active-high
Valid_i  in  1  operation request
Ready_o  out  1  engine idle, request accepted when Valid_i&Ready_o
Mode_i  in  2  00 add, 01 sub, 10 cmp, 11 add-with-carry; sampled on accept
Carry_i  in  1  initial carry for mode 11; sampled on accept
A_i  in  W  operand A; sampled on accept
B_i  in  W  operand B; sampled on accept
Valid_o  out  1  result valid
Ready_i  in  1  consumer accepts result when Valid_o&Ready_i
D_o  out  W  result
Carry_o  out  1  final carry out (sub/cmp: 1 = no borrow, i.e. A>=B unsigned)
Zero_o  out  1  whole W-bit result == 0
Sign_o  out  1  MSB of W-bit result
Overflow_o  out  1  two's-complement overflow of the W-bit operation

Behaviour:
- Reset_i high at a rising edge: state IDLE, Ready_o=1, Valid_o=0, D_o=0, Carry_o=Zero_o=Sign_o=Overflow_o=0, operand/result registers cleared. Reset applies in any state, including mid-CALC and DONE; the in-flight operation is discarded.
- States: IDLE -> CALC on accept; CALC -> DONE after NumWords slice cycles; DONE -> IDLE on Valid_o&Ready_i.
- Ready_o=1 only in IDLE. Valid_i outside IDLE is ignored; no queuing.
- On accept: latch A, B, Mode. Initial carry: add 0, sub/cmp 1 with B inverted per slice, mode 11 Carry_i. Word index = 0, zero accumulator = 1.
- CALC: each cycle: slice i = A[i] + (B[i] or ~B[i]) + carry; store into result slice i (not stored in cmp); carry register updated; zero accumulator ANDed with (slice==0). On the last slice, overflow = carry into MSB XOR carry out of MSB.
- Latency: accepted at edge t gives Valid_o high from edge t+NumWords; flags and D_o update at the same edge.
- cmp mode: D_o=0; flags are those of A-B (Zero_o=1 iff A==B; Carry_o=1 iff A>=B unsigned; Sign_o^Overflow_o=1 iff A<B signed).
- DONE: Valid_o=1, all outputs held stable while Ready_i=0, for any number of cycles. Ready_i in the DONE cycle gives IDLE next cycle, Valid_o=0, and outputs hold their last values.
- NumWords=1: CALC lasts exactly one cycle.
- Carry chaining across results is achieved externally via mode 11 with Carry_i=Carry_o.

Optional Feature:
ADDSUBCMP_SEQ_SATURATE_EN
- Defined: in add/sub/add-with-carry, when Overflow_o=1, D_o is replaced at the DONE transition by the signed limit: 0x7FF..F if A is non-negative, 0x800..0 if A is negative. Flags still report the raw result (Overflow_o=1). Latency is unchanged. cmp is unaffected.
- Undefined: D_o wraps modulo 2^W.

Decomposition:
- Package addsubcmp_pkg: mode constants (MODE_ADD, MODE_SUB, MODE_CMP, MODE_ADDC) and state encoding (ST_IDLE, ST_CALC, ST_DONE).
- Sub-module addsubcmp_slice: combinational WordWidth add with optional B inversion, Carry in/out, and MSB carry-in for overflow. Instantiated once. The sequencing registers live in addsubcmp_seq.

Test Plan (WordWidth=16, NumWords=4, W=64):
- add A=0x0000_0000_0000_FFFF, B=1 -> D_o=0x0000_0000_0001_0000, Carry_o=0, Zero_o=0, Overflow_o=0; Valid_o rises exactly 4 cycles after the accept edge.
- sub A=0, B=1 -> D_o=0xFFFF_FFFF_FFFF_FFFF, Carry_o=0, Sign_o=1, Overflow_o=0; mode 11 with Carry_i=1, A=B=0xFFFF_FFFF_FFFF_FFFF -> D_o=0xFFFF_FFFF_FFFF_FFFF, Carry_o=1.
- cmp A=B=0x1234_5678_9ABC_DEF0 -> Zero_o=1, Carry_o=1, D_o=0; cmp A=1, B=2 -> Zero_o=0, Carry_o=0, Sign_o=1.
- add A=0x7FFF_FFFF_FFFF_FFFF, B=1 -> Overflow_o=1, Sign_o=1, D_o=0x8000_0000_0000_0000 without the macro, 0x7FFF_FFFF_FFFF_FFFF with ADDSUBCMP_SEQ_SATURATE_EN.
- Backpressure: hold Ready_i=0 for 3 DONE cycles while pulsing Valid_i -> D_o and flags stable, Ready_o=0, the extra request is not executed; Ready_i=1 -> IDLE next cycle with Ready_o=1.
- Reset_i pulsed in the 2nd CALC cycle -> next cycle Ready_o=1, Valid_o=0, D_o=0, all flags 0; Valid_o never rises for the aborted operation.
